// File: rtl/ahb2apb_pkg.sv
// Shared types and helpers for the AHB-Lite to multi-slave APB bridge.
// Holds HTRANS encodings, the bridge state enum and the byte-strobe generator.
package ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Contiguous run of 2**size ones, placed at the size-aligned byte offset
  // within a beat of strb_w bytes (strb_w <= 8).
  function automatic logic [7:0] strb_gen(input logic [2:0] size,
                                          input logic [2:0] addr_lo,
                                          input int unsigned strb_w);
    int unsigned nbytes;
    int unsigned off;
    logic [7:0]  ones;
    nbytes = 32'd1 << size;
    off    = 32'(addr_lo) & (strb_w - 32'd1) & ~(nbytes - 32'd1);
    ones   = 8'((32'd1 << nbytes) - 32'd1);
    return 8'(32'(ones) << off);
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_nslv_if.sv
// Bus bundle between an AHB-Lite master / APB slaves and the bridge.
// The bridge uses the slave modport; the environment uses the master modport.
interface ahb2apb_bridge_nslv_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
) ();

  logic                       hsel;
  logic [ADDR_W-1:0]          haddr;
  logic [1:0]                 htrans;
  logic                       hwrite;
  logic [2:0]                 hsize;
  logic [DATA_W-1:0]          hwdata;
  logic                       hready_in;
  logic                       hreadyout;
  logic                       hresp;
  logic [DATA_W-1:0]          hrdata;

  logic [ADDR_W-1:0]          paddr;
  logic [NUM_SLV-1:0]         psel;
  logic                       penable;
  logic                       pwrite;
  logic [DATA_W-1:0]          pwdata;
  logic [DATA_W/8-1:0]        pstrb;
  logic [NUM_SLV-1:0]         pready;
  logic [NUM_SLV-1:0]         pslverr;
  logic [NUM_SLV*DATA_W-1:0]  prdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    input  pready, pslverr, prdata,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    output pready, pslverr, prdata,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );

endinterface

// File: rtl/apb_slave_mux.sv
// Selects the addressed APB slave's response (pready/pslverr/prdata)
// using the slave index registered at transfer acceptance.
module apb_slave_mux #(
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 3
) (
  input  logic [IDX_W-1:0]          idx,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  output logic                      sel_ready,
  output logic                      sel_err,
  output logic [DATA_W-1:0]         sel_rdata
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_nslv.sv
// AHB-Lite slave to APB master bridge fanning out to NUM_SLV one-hot selected
// APB slaves, with decode/slave errors and an optional PREADY timeout.
module ahb2apb_bridge_nslv
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 hresetn,
  ahb2apb_bridge_nslv_if.slave bus
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);
  // Wide enough to hold NUM_SLV itself, so the first window past the last
  // slave (and beyond) decodes as an error instead of aliasing.
  localparam int IDX_W    = $clog2(NUM_SLV + 1);
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [ADDR_W-1:0]   paddr_q,     paddr_d;
  logic                pwrite_q,    pwrite_d;
  logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_W-1:0]   pstrb_q,     pstrb_d;
  logic [DATA_W-1:0]   hrdata_q,    hrdata_d;
  logic [CNT_W-1:0]    tcnt_q,      tcnt_d;
  logic [NUM_SLV-1:0]  psel_q,      psel_d;
  logic                penable_q,   penable_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q,     hresp_d;

  logic                accept;
  logic                dec_err;
  logic [IDX_W-1:0]    req_idx;
  logic [STRB_W-1:0]   req_strb;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                to_hit;
  logic [CNT_W-1:0]    tcnt_inc;

  assign accept   = bus.hsel && bus.hready_in &&
                    (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
  assign req_idx  = bus.haddr[SLV_LSB +: IDX_W];
  assign dec_err  = (32'(req_idx) >= NUM_SLV) || (32'(bus.hsize) > MAX_SIZE);
  assign req_strb = bus.hwrite ? STRB_W'(strb_gen(bus.hsize, bus.haddr[2:0], STRB_W)) : '0;

  if (TIMEOUT > 0) begin : g_timeout
    assign to_hit   = (32'(tcnt_q) >= TIMEOUT - 1);
    assign tcnt_inc = (32'(tcnt_q) < TIMEOUT) ? tcnt_q + 1'b1 : tcnt_q;
  end else begin : g_no_timeout
    assign to_hit   = 1'b0;
    assign tcnt_inc = '0;
  end

  apb_slave_mux #(
    .DATA_W  (DATA_W),
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) u_mux (
    .idx       (idx_q),
    .pready    (bus.pready),
    .pslverr   (bus.pslverr),
    .prdata    (bus.prdata),
    .sel_ready (sel_ready),
    .sel_err   (sel_err),
    .sel_rdata (sel_rdata)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    hrdata_d = hrdata_q;
    tcnt_d   = tcnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (dec_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d  = ST_CAPT;
            idx_d    = req_idx;
            paddr_d  = bus.haddr;
            pwrite_d = bus.hwrite;
            pstrb_d  = req_strb;
          end
        end
      end
      ST_CAPT: begin
        pwdata_d = bus.hwdata;
        tcnt_d   = '0;
        state_d  = ST_SETUP;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          if (!pwrite_q) hrdata_d = sel_rdata;
          state_d = sel_err ? ST_ERR1 : ST_DONE;
        end else begin
          tcnt_d = tcnt_inc;
          if (to_hit) state_d = ST_ERR1;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase

    // Bus-facing outputs are a pure function of the next state so they come
    // straight from flops.
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    penable_d   = (state_d == ST_ACCESS);
    psel_d      = (state_d == ST_SETUP || state_d == ST_ACCESS) ? (NUM_SLV'(1) << idx_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      hrdata_q    <= '0;
      tcnt_q      <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      hrdata_q    <= hrdata_d;
      tcnt_q      <= tcnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge_nslv.sv
// Self-checking bench for ahb2apb_bridge_nslv: directed vector table, reset
// corner cases and randomized transfers against a transaction-level model.
module tb_ahb2apb_bridge_nslv;
  import ahb2apb_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int NSLV    = 4;

  logic clk = 1'b0;
  logic hresetn;
  always #5 clk = ~clk;

  ahb2apb_bridge_nslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NSLV)) bus ();

  ahb2apb_bridge_nslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(NSLV), .SLV_LSB(12), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        slverr;
    logic        exp_dec;
    logic [3:0]  exp_psel;
    logic [3:0]  exp_strb;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  string       cur_tag = "reset";
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    bus.hsel      = 1'b0;
    bus.htrans    = HTRANS_IDLE;
    bus.hready_in = 1'b1;
  endtask

  // Expected strobes: bytes [first, first+n) of the 4-byte beat.
  function automatic logic [3:0] model_strb(input logic wr, input logic [31:0] addr,
                                            input logic [2:0] size);
    int n, lo, first;
    logic [3:0] m;
    m = '0;
    if (!wr) return m;
    n     = 1 << size;
    lo    = int'(addr % 4);
    first = lo - (lo % n);
    for (int b = 0; b < 4; b++) m[b] = (b >= first) && (b < first + n);
    return m;
  endfunction

  // One full AHB transfer, started in a cycle where the bridge is ready.
  task automatic do_xfer(input vec_t v);
    int   n_acc;
    logic timed_out;
    timed_out = (v.waits >= TIMEOUT);
    n_acc     = timed_out ? TIMEOUT : v.waits + 1;

    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hready_in = 1'b1;
    bus.haddr = v.addr; bus.hwrite = v.wr; bus.hsize = v.size;
    for (int i = 0; i < NSLV; i++)
      bus.prdata[i*32 +: 32] = v.exp_psel[i] ? v.rdata : (~v.rdata ^ 32'(i));
    tick;
    // Data phase: scramble address-phase signals to catch late sampling.
    bus_idle;
    bus.hwdata = v.wdata;
    bus.haddr  = $urandom;
    bus.hwrite = ~v.wr;
    bus.hsize  = 3'($urandom_range(0, 7));
    if (v.exp_dec) begin
      check("err1_hresp", 64'(bus.hresp), 64'd1);
      check("err1_hready", 64'(bus.hreadyout), 64'd0);
      check("err1_psel", 64'(bus.psel), 64'd0);
      tick;
      check("err2_hresp", 64'(bus.hresp), 64'd1);
      check("err2_hready", 64'(bus.hreadyout), 64'd1);
      check("err2_psel", 64'(bus.psel), 64'd0);
      return;
    end
    check("capt_hready", 64'(bus.hreadyout), 64'd0);
    check("capt_psel", 64'(bus.psel), 64'd0);
    check("capt_hresp", 64'(bus.hresp), 64'd0);
    tick;
    check("setup_psel", 64'(bus.psel), 64'(v.exp_psel));
    check("setup_penable", 64'(bus.penable), 64'd0);
    check("setup_paddr", 64'(bus.paddr), 64'(v.addr));
    check("setup_pwrite", 64'(bus.pwrite), 64'(v.wr));
    check("setup_pstrb", 64'(bus.pstrb), 64'(v.exp_strb));
    if (v.wr) check("setup_pwdata", 64'(bus.pwdata), 64'(v.wdata));
    tick;
    for (int i = 0; i < n_acc; i++) begin
      check("acc_psel", 64'(bus.psel), 64'(v.exp_psel));
      check("acc_penable", 64'(bus.penable), 64'd1);
      check("acc_paddr", 64'(bus.paddr), 64'(v.addr));
      check("acc_pstrb", 64'(bus.pstrb), 64'(v.exp_strb));
      if (v.wr) check("acc_pwdata", 64'(bus.pwdata), 64'(v.wdata));
      // Unselected slaves show the opposite ready/error to expose a bad mux.
      bus.pready  = (i == v.waits) ? v.exp_psel : ~v.exp_psel;
      bus.pslverr = (v.slverr ? v.exp_psel : 4'b0) | ~v.exp_psel;
      tick;
    end
    bus.pready = '0; bus.pslverr = '0;
    if (!timed_out && !v.wr && !v.slverr) last_rd = v.rdata;
    if (timed_out || v.slverr) begin
      check("apb_err1_hresp", 64'(bus.hresp), 64'd1);
      check("apb_err1_hready", 64'(bus.hreadyout), 64'd0);
      check("apb_err1_psel", 64'(bus.psel), 64'd0);
      check("apb_err1_penable", 64'(bus.penable), 64'd0);
      tick;
      check("apb_err2_hresp", 64'(bus.hresp), 64'd1);
      check("apb_err2_hready", 64'(bus.hreadyout), 64'd1);
    end else begin
      check("done_hready", 64'(bus.hreadyout), 64'd1);
      check("done_hresp", 64'(bus.hresp), 64'd0);
      check("done_psel", 64'(bus.psel), 64'd0);
      check("done_penable", 64'(bus.penable), 64'd0);
      check("done_hrdata", 64'(bus.hrdata), 64'(last_rd));
    end
  endtask

  task automatic idle_cycle;
    bus_idle;
    tick;
    check("idle_hready", 64'(bus.hreadyout), 64'd1);
    check("idle_hresp", 64'(bus.hresp), 64'd0);
    check("idle_psel", 64'(bus.psel), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    int   slv;

    //          wr    addr           size  wdata          rdata          w  err   dec   psel     strb
    tbl[0]  = '{1'b1, 32'h0000_1004, 3'd2, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 1'b0, 4'b0010, 4'hF};
    tbl[1]  = '{1'b0, 32'h0000_3008, 3'd2, 32'h0,         32'h1234_5678, 3, 1'b0, 1'b0, 4'b1000, 4'h0};
    tbl[2]  = '{1'b1, 32'h0000_2003, 3'd0, 32'hAB00_0000, 32'h0,         1, 1'b0, 1'b0, 4'b0100, 4'b1000};
    tbl[3]  = '{1'b1, 32'h0000_2002, 3'd1, 32'h5A5A_0000, 32'h0,         0, 1'b0, 1'b0, 4'b0100, 4'b1100};
    tbl[4]  = '{1'b1, 32'h0000_5000, 3'd2, 32'h1111_1111, 32'h0,         0, 1'b0, 1'b1, 4'b0000, 4'h0};
    tbl[5]  = '{1'b1, 32'h0000_0000, 3'd2, 32'h2222_2222, 32'h0,         0, 1'b1, 1'b0, 4'b0001, 4'hF};
    tbl[6]  = '{1'b1, 32'h0000_0010, 3'd2, 32'h3333_3333, 32'h0,         9, 1'b0, 1'b0, 4'b0001, 4'hF};
    tbl[7]  = '{1'b1, 32'h0000_0020, 3'd2, 32'h4444_4444, 32'h0,         0, 1'b0, 1'b0, 4'b0001, 4'hF};
    tbl[8]  = '{1'b1, 32'h0000_2024, 3'd2, 32'h5555_5555, 32'h0,         0, 1'b0, 1'b0, 4'b0100, 4'hF};
    tbl[9]  = '{1'b0, 32'h0000_1002, 3'd1, 32'h0,         32'h9ABC_DEF0, 1, 1'b0, 1'b0, 4'b0010, 4'h0};
    tbl[10] = '{1'b1, 32'h0000_1000, 3'd3, 32'h6666_6666, 32'h0,         0, 1'b0, 1'b1, 4'b0000, 4'h0};
    tbl[11] = '{1'b1, 32'h0000_7000, 3'd2, 32'h7777_7777, 32'h0,         0, 1'b0, 1'b1, 4'b0000, 4'h0};

    hresetn = 1'b0;
    bus_idle;
    bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = '0; bus.hwdata = '0;
    bus.pready = '0; bus.pslverr = '0; bus.prdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hready", 64'(bus.hreadyout), 64'd1);
    check("rst_hresp", 64'(bus.hresp), 64'd0);
    check("rst_psel", 64'(bus.psel), 64'd0);
    check("rst_penable", 64'(bus.penable), 64'd0);
    check("rst_pwrite", 64'(bus.pwrite), 64'd0);
    check("rst_paddr", 64'(bus.paddr), 64'd0);
    check("rst_pwdata", 64'(bus.pwdata), 64'd0);
    check("rst_pstrb", 64'(bus.pstrb), 64'd0);
    check("rst_hrdata", 64'(bus.hrdata), 64'd0);
    hresetn = 1'b1;
    idle_cycle;

    // Non-transfers that must be ignored.
    cur_tag = "ignore";
    bus.hsel = 1'b1; bus.htrans = HTRANS_BUSY; bus.haddr = 32'h1000;
    tick;
    check("busy_hready", 64'(bus.hreadyout), 64'd1);
    bus.htrans = HTRANS_NONSEQ; bus.hready_in = 1'b0;
    tick;
    check("nordy_hready", 64'(bus.hreadyout), 64'd1);
    bus.hready_in = 1'b1; bus.hsel = 1'b0;
    tick;
    check("nosel_hready", 64'(bus.hreadyout), 64'd1);
    idle_cycle;

    // Directed table, issued back to back.
    for (int i = 0; i < 12; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_xfer(tbl[i]);
    end
    cur_tag = "after_table";
    idle_cycle;

    // Asynchronous reset in the middle of an ACCESS phase.
    cur_tag = "reset_mid";
    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h2000;
    bus.hwrite = 1'b0; bus.hsize = 3'd2;
    tick;
    bus_idle;
    tick;
    tick;
    check("mid_penable", 64'(bus.penable), 64'd1);
    check("mid_psel", 64'(bus.psel), 64'b0100);
    #2 hresetn = 1'b0;
    #1;
    check("rst_now_psel", 64'(bus.psel), 64'd0);
    check("rst_now_penable", 64'(bus.penable), 64'd0);
    check("rst_now_hready", 64'(bus.hreadyout), 64'd1);
    check("rst_now_hrdata", 64'(bus.hrdata), 64'd0);
    @(posedge clk);
    #1 hresetn = 1'b1;
    last_rd = '0;
    idle_cycle;

    // Randomized transfers against the transaction model.
    for (int n = 0; n < 60; n++) begin
      cur_tag  = $sformatf("rand%0d", n);
      slv      = $urandom_range(0, 5);
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = (32'(slv) << 12) | ($urandom & 32'hFFF);
      v.size   = 3'($urandom_range(0, 3));
      v.wdata  = $urandom;
      v.rdata  = $urandom;
      v.waits  = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2)
                                             : $urandom_range(0, 3);
      v.slverr = v.wr && ($urandom_range(0, 7) == 0);
      v.exp_dec  = (slv >= NSLV) || (v.size > 3'd2);
      v.exp_psel = v.exp_dec ? 4'b0 : 4'(1 << slv);
      v.exp_strb = model_strb(v.wr, v.addr, v.size);
      do_xfer(v);
      if ($urandom_range(0, 2) == 0) idle_cycle;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
